// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the multi-cycle CPU's unified memory: the CPU port (m0) and the
// debug/loader port (m1) take turns by round-robin, and each access runs issue -> wait -> return.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

   state_t              state_q;
   logic                last_grant_q;
   logic                winner_q;
   logic [3:0]          count_q;
   logic                m0_gnt_q, m1_gnt_q;
   logic                m0_rvalid_q, m1_rvalid_q;
   logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;
   logic                mem_en_q, mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   logic                winner_d;
   logic                win_we_d;
   logic [ADDR_W-1:0]   win_addr_d;
   logic [DATA_W-1:0]   win_wdata_d;

   // Under contention the master that did not win last time goes first.
   always_comb begin
      winner_d = m1_req_i;
      if (m0_req_i && m1_req_i) begin
         winner_d = ~last_grant_q;
      end
      win_we_d    = winner_d ? m1_we_i    : m0_we_i;
      win_addr_d  = winner_d ? m1_addr_i  : m0_addr_i;
      win_wdata_d = winner_d ? m1_wdata_i : m0_wdata_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         winner_q     <= 1'b0;
         count_q      <= 4'd0;
         m0_gnt_q     <= 1'b0;
         m1_gnt_q     <= 1'b0;
         m0_rvalid_q  <= 1'b0;
         m1_rvalid_q  <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         m0_gnt_q    <= 1'b0;
         m1_gnt_q    <= 1'b0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (m0_req_i || m1_req_i) begin
                  winner_q     <= winner_d;
                  last_grant_q <= winner_d;
                  mem_en_q     <= 1'b1;
                  mem_we_q     <= win_we_d;
                  mem_addr_q   <= win_addr_d;
                  mem_wdata_q  <= win_wdata_d;
                  m0_gnt_q     <= ~winner_d;
                  m1_gnt_q     <= winner_d;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               // mem_we_q still holds the issued access type during this cycle.
               if (mem_we_q) begin
                  state_q <= IDLE;
               end else begin
                  count_q <= 4'd1;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (count_q == LAT_CNT) begin
                  if (winner_q) begin
                     m1_rdata_q  <= mem_rdata_i;
                     m1_rvalid_q <= 1'b1;
                  end else begin
                     m0_rdata_q  <= mem_rdata_i;
                     m0_rvalid_q <= 1'b1;
                  end
                  count_q <= 4'd0;
                  state_q <= IDLE;
               end else begin
                  count_q <= count_q + 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign m0_gnt_o    = m0_gnt_q;
   assign m1_gnt_o    = m1_gnt_q;
   assign m0_rvalid_o = m0_rvalid_q;
   assign m1_rvalid_o = m1_rvalid_q;
   assign m0_rdata_o  = m0_rdata_q;
   assign m1_rdata_o  = m1_rdata_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances (MEM_LAT 2, 3, 1, 15) share one stimulus,
// each with its own memory model; directed tasks check one instance each.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int N  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;

   logic          m0_gnt_w [N];
   logic          m1_gnt_w [N];
   logic          m0_rvalid_w [N];
   logic          m1_rvalid_w [N];
   logic [DW-1:0] m0_rdata_w [N];
   logic [DW-1:0] m1_rdata_w [N];
   logic          mem_en_w [N];
   logic          mem_we_w [N];
   logic [AW-1:0] mem_addr_w [N];
   logic [DW-1:0] mem_wdata_w [N];
   logic [DW-1:0] mem_rdata_w [N];
   logic          busy_w [N];

   int checks = 0;
   int passed = 0;

   function automatic logic [31:0] init_word(input logic [7:0] idx);
      return (idx == 8'd4) ? 32'h8C020004 : (32'hC0DE0000 | {24'd0, idx});
   endfunction

   for (genvar gi = 0; gi < N; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 3 : (gi == 2) ? 1 : 15;
      logic [31:0] mem [256];
      logic [31:0] pd [16];
      logic        pv [16];

      // Read data appears exactly LAT cycles after mem_en; a poison word otherwise.
      always @(posedge clk) begin
         if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
            for (int k = 0; k < 16; k++) pv[k] <= 1'b0;
         end else begin
            if (mem_en_w[gi] && mem_we_w[gi]) mem[mem_addr_w[gi][9:2]] <= mem_wdata_w[gi];
            pd[0] <= mem[mem_addr_w[gi][9:2]];
            pv[0] <= mem_en_w[gi] && !mem_we_w[gi];
            for (int k = 1; k < 16; k++) begin
               pd[k] <= pd[k-1];
               pv[k] <= pv[k-1];
            end
         end
      end
      assign mem_rdata_w[gi] = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0BAD0;

      mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
         .clk(clk), .reset(reset),
         .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
         .m0_gnt_o(m0_gnt_w[gi]), .m0_rvalid_o(m0_rvalid_w[gi]), .m0_rdata_o(m0_rdata_w[gi]),
         .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
         .m1_gnt_o(m1_gnt_w[gi]), .m1_rvalid_o(m1_rvalid_w[gi]), .m1_rdata_o(m1_rdata_w[gi]),
         .mem_en_o(mem_en_w[gi]), .mem_we_o(mem_we_w[gi]), .mem_addr_o(mem_addr_w[gi]),
         .mem_wdata_o(mem_wdata_w[gi]), .mem_rdata_i(mem_rdata_w[gi]), .busy_o(busy_w[gi])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_all_idle();
      int n = 0;
      while ((busy_w[0] || busy_w[1] || busy_w[2] || busy_w[3]) && n < 60) begin
         tick();
         n++;
      end
      tick();
      tick();
      checks++;
      if (n >= 60) $display("FAIL idle_timeout: busy still high after %0d cycles, required idle", n);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
      tick();
      tick();
      checks++;
      if ({m0_gnt_w[0], m1_gnt_w[0], m0_rvalid_w[0], m1_rvalid_w[0], mem_en_w[0], mem_we_w[0], busy_w[0]} !== 7'b0)
         $display("FAIL reset_flags: got %b required 0000000", {m0_gnt_w[0], m1_gnt_w[0], m0_rvalid_w[0],
                  m1_rvalid_w[0], mem_en_w[0], mem_we_w[0], busy_w[0]});
      else passed++;
      checks++;
      if ({mem_addr_w[0], mem_wdata_w[0]} !== 64'd0)
         $display("FAIL reset_mem_bus: got addr %h wdata %h required 0", mem_addr_w[0], mem_wdata_w[0]);
      else passed++;
      checks++;
      if ({m0_rdata_w[0], m1_rdata_w[0]} !== 64'd0)
         $display("FAIL reset_rdata: got m0 %h m1 %h required 0", m0_rdata_w[0], m1_rdata_w[0]);
      else passed++;
      reset = 1'b0;
      tick();
      $display("reset: done");
   endtask

   task automatic test_single_read();
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      tick();
      checks++;
      if ({m0_gnt_w[0], m1_gnt_w[0], mem_en_w[0], mem_we_w[0], busy_w[0]} !== 5'b10101)
         $display("FAIL read_issue: got gnt0/gnt1/en/we/busy %b required 10101",
                  {m0_gnt_w[0], m1_gnt_w[0], mem_en_w[0], mem_we_w[0], busy_w[0]});
      else passed++;
      checks++;
      if (mem_addr_w[0] !== 32'h10) $display("FAIL read_addr: got %h required 00000010", mem_addr_w[0]);
      else passed++;
      m0_req = 0;
      for (int c = 2; c <= 3; c++) begin
         tick();
         checks++;
         if ({m0_gnt_w[0], mem_en_w[0], m0_rvalid_w[0], busy_w[0]} !== 4'b0001)
            $display("FAIL read_wait_t%0d: got gnt/en/rvalid/busy %b required 0001", c,
                     {m0_gnt_w[0], mem_en_w[0], m0_rvalid_w[0], busy_w[0]});
         else passed++;
      end
      tick();
      checks++;
      if ({m0_rvalid_w[0], m1_rvalid_w[0], busy_w[0]} !== 3'b100)
         $display("FAIL read_rvalid: got rv0/rv1/busy %b required 100", {m0_rvalid_w[0], m1_rvalid_w[0], busy_w[0]});
      else passed++;
      checks++;
      if (m0_rdata_w[0] !== 32'h8C020004) $display("FAIL read_data: got %h required 8c020004", m0_rdata_w[0]);
      else passed++;
      tick();
      checks++;
      if (m0_rvalid_w[0] !== 1'b0 || m0_rdata_w[0] !== 32'h8C020004)
         $display("FAIL read_hold: got rvalid %b rdata %h required 0 8c020004", m0_rvalid_w[0], m0_rdata_w[0]);
      else passed++;
      $display("read m0 addr 00000010 data %h", m0_rdata_w[0]);
      wait_all_idle();
   endtask

   task automatic test_single_write();
      int rv = 0;
      int n  = 0;
      m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hDEADBEEF;
      tick();
      checks++;
      if ({m0_gnt_w[0], m1_gnt_w[0], mem_en_w[0], mem_we_w[0]} !== 4'b0111)
         $display("FAIL write_issue: got gnt0/gnt1/en/we %b required 0111",
                  {m0_gnt_w[0], m1_gnt_w[0], mem_en_w[0], mem_we_w[0]});
      else passed++;
      checks++;
      if (mem_addr_w[0] !== 32'h40 || mem_wdata_w[0] !== 32'hDEADBEEF)
         $display("FAIL write_bus: got addr %h data %h required 00000040 deadbeef", mem_addr_w[0], mem_wdata_w[0]);
      else passed++;
      m1_req = 0; m1_we = 0;
      tick();
      checks++;
      if ({busy_w[0], mem_en_w[0]} !== 2'b00)
         $display("FAIL write_occupancy: got busy/en %b required 00", {busy_w[0], mem_en_w[0]});
      else passed++;
      for (int c = 0; c < 4; c++) begin
         if (m0_rvalid_w[0] || m1_rvalid_w[0]) rv++;
         tick();
      end
      checks++;
      if (rv !== 0) $display("FAIL write_no_rvalid: got %0d rvalid pulses required 0", rv);
      else passed++;
      $display("write m1 addr 00000040 data deadbeef");
      m0_req = 1; m0_we = 0; m0_addr = 32'h40;
      tick();
      m0_req = 0;
      while (!m0_rvalid_w[0] && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (m0_rvalid_w[0] !== 1'b1 || m0_rdata_w[0] !== 32'hDEADBEEF)
         $display("FAIL readback: got rvalid %b data %h required 1 deadbeef", m0_rvalid_w[0], m0_rdata_w[0]);
      else passed++;
      $display("read m0 addr 00000040 data %h", m0_rdata_w[0]);
      wait_all_idle();
   endtask

   task automatic test_contention();
      int ngr = 0;
      int cyc = 0;
      logic owner = 1'b0;
      logic got;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      m1_req = 1; m1_we = 0; m1_addr = 32'h20;
      while (ngr < 4 && cyc < 80) begin
         tick();
         cyc++;
         if (m0_rvalid_w[0] || m1_rvalid_w[0]) begin
            checks++;
            if (m1_rvalid_w[0] !== owner || (m0_rvalid_w[0] && m1_rvalid_w[0]))
               $display("FAIL cont_rvalid_owner: got rv0/rv1 %b%b required owner m%0d", m0_rvalid_w[0], m1_rvalid_w[0], owner);
            else passed++;
            checks++;
            if (m0_rvalid_w[0] ? (m0_rdata_w[0] !== 32'h8C020004) : (m1_rdata_w[0] !== 32'hC0DE0008))
               $display("FAIL cont_rdata: got m0 %h m1 %h required m0 8c020004 / m1 c0de0008", m0_rdata_w[0], m1_rdata_w[0]);
            else passed++;
         end
         if (m0_gnt_w[0] || m1_gnt_w[0]) begin
            got = m1_gnt_w[0];
            checks++;
            if ((m0_gnt_w[0] && m1_gnt_w[0]) || got !== ngr[0])
               $display("FAIL cont_grant%0d: got gnt0/gnt1 %b%b required m%0d", ngr, m0_gnt_w[0], m1_gnt_w[0], ngr[0]);
            else passed++;
            $display("contention grant %0d to m%0d at cycle %0d", ngr, got, cyc);
            owner = got;
            ngr++;
         end
      end
      checks++;
      if (ngr != 4) $display("FAIL cont_timeout: got %0d grants required 4", ngr);
      else passed++;
      m0_req = 0; m1_req = 0;
      wait_all_idle();
   endtask

   task automatic test_reset_mid_read();
      int rv = 0;
      int n  = 0;
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      tick();
      m0_req = 0;
      tick();
      tick();
      checks++;
      if (busy_w[1] !== 1'b1) $display("FAIL rst_mid_setup: got busy %b required 1", busy_w[1]);
      else passed++;
      reset = 1'b1;
      #1;
      checks++;
      if ({m0_gnt_w[1], m1_gnt_w[1], m0_rvalid_w[1], m1_rvalid_w[1], mem_en_w[1], mem_we_w[1], busy_w[1]} !== 7'b0)
         $display("FAIL rst_mid_flags: got %b required 0000000", {m0_gnt_w[1], m1_gnt_w[1], m0_rvalid_w[1],
                  m1_rvalid_w[1], mem_en_w[1], mem_we_w[1], busy_w[1]});
      else passed++;
      checks++;
      if ({m0_rdata_w[1], mem_addr_w[1]} !== 64'd0)
         $display("FAIL rst_mid_data: got rdata %h addr %h required 0", m0_rdata_w[1], mem_addr_w[1]);
      else passed++;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (m0_rvalid_w[1] || m1_rvalid_w[1]) rv++;
      end
      checks++;
      if (rv !== 0) $display("FAIL rst_mid_no_rvalid: got %0d pulses required 0", rv);
      else passed++;
      m0_req = 1; m1_req = 1; m1_addr = 32'h20; m1_we = 0;
      tick();
      while (!m0_gnt_w[1] && !m1_gnt_w[1] && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if ({m0_gnt_w[1], m1_gnt_w[1]} !== 2'b10)
         $display("FAIL rst_mid_first_winner: got gnt0/gnt1 %b%b required 10", m0_gnt_w[1], m1_gnt_w[1]);
      else passed++;
      $display("reset mid-read: next winner m%0d", m1_gnt_w[1]);
      m0_req = 0; m1_req = 0;
      wait_all_idle();
   endtask

   task automatic test_latency_sweep();
      int lat_a = -1;
      int lat_b = -1;
      logic [31:0] d_a = '0;
      logic [31:0] d_b = '0;
      int m1_bad = 0;
      m1_req = 1; m1_we = 0; m1_addr = 32'h20;
      tick();
      m1_req = 0;
      wait_all_idle();
      m0_req = 1; m0_we = 0; m0_addr = 32'h10;
      tick();
      checks++;
      if ({m0_gnt_w[2], m0_gnt_w[3]} !== 2'b11)
         $display("FAIL lat_gnt: got gnt lat1/lat15 %b%b required 11", m0_gnt_w[2], m0_gnt_w[3]);
      else passed++;
      m0_req = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (m0_rvalid_w[2] && lat_a < 0) begin lat_a = k; d_a = m0_rdata_w[2]; end
         if (m0_rvalid_w[3] && lat_b < 0) begin lat_b = k; d_b = m0_rdata_w[3]; end
         if (m1_rvalid_w[2] || m1_rvalid_w[3] || m1_rdata_w[2] !== 32'hC0DE0008 || m1_rdata_w[3] !== 32'hC0DE0008)
            m1_bad++;
      end
      checks++;
      if (lat_a !== 2) $display("FAIL lat1_cycles: got %0d required 2", lat_a);
      else passed++;
      checks++;
      if (lat_b !== 16) $display("FAIL lat15_cycles: got %0d required 16", lat_b);
      else passed++;
      checks++;
      if (d_a !== 32'h8C020004 || d_b !== 32'h8C020004)
         $display("FAIL lat_rdata: got %h %h required 8c020004", d_a, d_b);
      else passed++;
      checks++;
      if (m1_bad !== 0) $display("FAIL lat_m1_hold: got %0d disturbed cycles required 0", m1_bad);
      else passed++;
      $display("latency sweep: lat1 %0d cycles, lat15 %0d cycles", lat_a, lat_b);
      wait_all_idle();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_reset_mid_read();
      test_latency_sweep();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
